// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register window, small TX FIFO,
// and a registered serialiser so the tx line never glitches.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
    parameter int          CLK_DIV    = 104,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              tx_q, tx_nxt;
    logic              pop;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic full, empty, busy;
    logic push_req, push, ovf_clr;
    logic [31:0] status;

    // Upper strobes and address/data bits outside the byte lane are don't-care.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};

    assign sel      = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign push_req = sel & ~mem_addr[2] & mem_wstrb[0];
    assign push     = push_req & ~full;
    assign ovf_clr  = sel & mem_addr[2] & mem_wstrb[0] & mem_wdata[3];
    assign status   = {23'd0, 5'(count), overflow, empty, full, busy};
    assign tx       = tx_q;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    baud_nxt  = BAUD_LAST;
                    bit_nxt   = 3'd0;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_nxt  = BAUD_LAST;
                    tx_nxt    = shift[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_nxt = BAUD_LAST;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        // tx takes the next bit in the same edge as the shift
                        shift_nxt = {1'b0, shift[7:1]};
                        bit_nxt   = bit_idx + 3'd1;
                        tx_nxt    = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    tx_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            tx_q     <= tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
        if (push)
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (sel && mem_rstrb)
                mem_rdata <= mem_addr[2] ? status : 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: two instances (CLK_DIV=4 and CLK_DIV=2) on a shared clock/reset.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] mem_addr = BASE, mem_wdata = 32'd0, mem_rdata;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_rstrb = 1'b0, sel, tx;

    logic [31:0] b_addr = BASE, b_wdata = 32'd0, b_rdata;
    logic [3:0]  b_wstrb = 4'd0;
    logic        b_rstrb = 1'b0, b_sel, b_tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .sel(sel), .tx(tx)
    );

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_wstrb(b_wstrb), .mem_rstrb(b_rstrb), .mem_rdata(b_rdata),
        .sel(b_sel), .tx(b_tx)
    );

    function automatic logic txv(input bit which);
        return which ? b_tx : tx;
    endfunction

    // All drivers assume the caller sits 1 time unit after a rising edge.
    task automatic wr(input bit which, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        if (which) begin b_addr = addr; b_wdata = data; b_wstrb = strb; end
        else begin mem_addr = addr; mem_wdata = data; mem_wstrb = strb; end
        @(posedge clk); #1;
        if (which) b_wstrb = 4'd0; else mem_wstrb = 4'd0;
    endtask

    task automatic rd(input bit which, input logic [31:0] addr, output logic [31:0] d);
        if (which) begin b_addr = addr; b_rstrb = 1'b1; end
        else begin mem_addr = addr; mem_rstrb = 1'b1; end
        @(posedge clk); #1;
        if (which) begin b_rstrb = 1'b0; d = b_rdata; end
        else begin mem_rstrb = 1'b0; d = mem_rdata; end
    endtask

    // Records one frame cycle by cycle (bit i = tx in frame cycle i); got=0 if no start bit within budget.
    task automatic capture(input bit which, input int div, input int budget,
                           output logic [39:0] s, output logic [7:0] b,
                           output int waited, output bit got);
        got = 1'b0; waited = 0; s = '0; b = '0;
        for (int i = 0; i < budget; i++) begin
            if (txv(which) == 1'b0) begin got = 1'b1; break; end
            @(posedge clk); #1;
            waited++;
        end
        if (!got) return;
        for (int i = 0; i < 10 * div; i++) begin
            s[i] = txv(which);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 8; k++) b[k] = s[div * (k + 1) + div / 2];
    endtask

    task automatic test_reset;
        int bad;
        logic [31:0] d;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata); end
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_tx: %0d low cycles want 0", bad); end
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL idle_status: got %h want 00000004", d); end
    endtask

    task automatic test_single_byte;
        logic [39:0] s;
        logic [7:0]  b;
        logic [31:0] d;
        int w, bad;
        bit got;
        fork
            begin
                wr(0, BASE, 32'hDEAD_BE55, 4'b0001);
                wr(0, BASE, 32'hDEAD_BE55, 4'b0010);
                wr(0, BASE, 32'hDEAD_BE55, 4'b0100);
                wr(0, BASE, 32'hDEAD_BE55, 4'b1000);
            end
            capture(0, 4, 20, s, b, w, got);
        join
        checks++;
        if (!got || s !== 40'hF0F0F0F0F0)
            begin errors++; $display("FAIL single_frame: got %h (seen=%0d) want f0f0f0f0f0", s, got); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL single_only_one: %0d low cycles want 0", bad); end
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL single_status: got %h want 00000004", d); end
    endtask

    task automatic test_overflow;
        logic [39:0] s;
        logic [7:0]  b;
        logic [7:0]  exp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [31:0] d, st;
        int w;
        bit got;
        fork
            begin
                for (int i = 1; i <= 6; i++) wr(0, BASE, 32'(i), 4'b0001);
                rd(0, BASE + 32'd4, st);
            end
            capture(0, 4, 20, s, b, w, got);
        join
        checks++;
        if (st !== 32'h0000_004B) begin errors++; $display("FAIL ovf_status: got %h want 0000004b", st); end
        checks++;
        if (!got || b !== exp_b[0]) begin errors++; $display("FAIL ovf_byte0: got %h want %h", b, exp_b[0]); end
        for (int k = 1; k < 5; k++) begin
            capture(0, 4, 20, s, b, w, got);
            checks++;
            if (!got || b !== exp_b[k])
                begin errors++; $display("FAIL ovf_byte%0d: got %h (seen=%0d) want %h", k, b, got, exp_b[k]); end
        end
        capture(0, 4, 30, s, b, w, got);
        checks++;
        if (got) begin errors++; $display("FAIL ovf_dropped: extra frame %h want none", b); end
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_000C) begin errors++; $display("FAIL ovf_sticky: got %h want 0000000c", d); end
        wr(0, BASE + 32'd4, 32'h0000_0008, 4'b0001);
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL ovf_clear: got %h want 00000004", d); end
    endtask

    task automatic test_read_latency;
        logic [31:0] d;
        wr(0, BASE, 32'h11, 4'b0001);
        wr(0, BASE, 32'h22, 4'b0001);
        wr(0, BASE, 32'h33, 4'b0001);
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0021) begin errors++; $display("FAIL rd_status: got %h want 00000021", d); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_rdata !== 32'h0000_0021) begin errors++; $display("FAIL rd_hold: got %h want 00000021", mem_rdata); end
        mem_addr  = BASE + 32'd8;
        mem_rstrb = 1'b1;
        #1;
        checks++;
        if (sel !== 1'b0) begin errors++; $display("FAIL rd_sel_miss: got %b want 0", sel); end
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        checks++;
        if (mem_rdata !== 32'h0000_0021) begin errors++; $display("FAIL rd_miss_hold: got %h want 00000021", mem_rdata); end
        rd(0, BASE, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rd_data_reg: got %h want 00000000", d); end
        repeat (150) @(posedge clk);
        #1;
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL rd_drained: got %h want 00000004", d); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        int bad;
        wr(0, BASE, 32'h00, 4'b0001);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3_low: got %b want 0", tx); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx: got %b want 1", tx); end
        @(posedge clk); #1;
        rst = 1'b1;
        rd(0, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL mid_status: got %h want 00000004", d); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_no_resume: %0d low cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        logic [39:0] s;
        logic [7:0]  b;
        logic [31:0] d;
        int w;
        bit got;
        wr(1, BASE, 32'hA5, 4'b0001);
        wr(1, BASE, 32'h3C, 4'b0001);
        capture(1, 2, 10, s, b, w, got);
        checks++;
        if (!got || s[19:0] !== 20'hF30CC)
            begin errors++; $display("FAIL b2b_frame0: got %h (seen=%0d) want f30cc", s[19:0], got); end
        capture(1, 2, 10, s, b, w, got);
        checks++;
        if (!got || w != 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 1", w); end
        checks++;
        if (!got || s[19:0] !== 20'hC3FC0)
            begin errors++; $display("FAIL b2b_frame1: got %h (seen=%0d) want c3fc0", s[19:0], got); end
        rd(1, BASE + 32'd4, d);
        checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL b2b_status: got %h want 00000004", d); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_overflow;
        test_read_latency;
        test_reset_mid_frame;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
